// File: rtl/race_flow_controller_pkg.sv
// Shared definitions for the race sequencer and the physics engines:
// game state codes, winner codes and the state bus width.
package race_pkg;

  // Width of the game state bus, shared with both physics engines.
  localparam int STATE_W = 3;

  // Game state codes (legacy numeric encoding, kept as plain constants).
  localparam logic [STATE_W-1:0] ST_TITLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD      = 3'd1;
  localparam logic [STATE_W-1:0] ST_COUNTDOWN = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSED    = 3'd3;
  localparam logic [STATE_W-1:0] ST_RACE      = 3'd4;
  localparam logic [STATE_W-1:0] ST_FINISHED  = 3'd5;

  // Winner codes reported to the HUD.
  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_P1   = 2'd1;
  localparam logic [1:0] W_P2   = 2'd2;
  localparam logic [1:0] W_TIE  = 2'd3;

  // Map the per-player finish hits of one cycle onto a winner code.
  function automatic logic [1:0] winner_code(input logic hit_p1, input logic hit_p2);
    logic [1:0] code;
    case ({hit_p2, hit_p1})
      2'b01:   code = W_P1;
      2'b10:   code = W_P2;
      2'b11:   code = W_TIE;
      default: code = W_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/race_flow_controller_tick_divider.sv
// Free-running prescaler that emits a one-cycle tick every DIV enabled
// cycles. The count holds while en is low so a paused timer resumes
// exactly where it stopped; clr restarts the count from zero.
module tick_divider #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i & (cnt_q == LAST);

  // Next count: clear, wrap at LAST, advance when enabled, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/race_flow_controller.sv
// Top-level race sequencer: title/load/countdown/race/pause/finish flow,
// race timer in centiseconds and winner decision from the engines'
// finish levels. All outputs come straight from registers.
module race_flow_controller
  import race_pkg::*;
#(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          COUNT_SECS = 3,
  parameter logic [15:0] TIME_MAX   = 16'd65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn_i,
  input  logic               pause_btn_i,
  input  logic               finish_p1_i,
  input  logic               finish_p2_i,
  output logic [STATE_W-1:0] state_o,
  output logic               car_rst_o,
  output logic [1:0]         countdown_val_o,
  output logic [15:0]        race_time_cs_o,
  output logic [1:0]         winner_o
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               car_rst_q, car_rst_d;
  logic [1:0]         countdown_q, countdown_d;
  logic [15:0]        time_q, time_d;
  logic [1:0]         winner_q, winner_d;
  logic               armed_p1_q, armed_p1_d;
  logic               armed_p2_q, armed_p2_d;

  logic sec_en_s, sec_clr_s, sec_tick_s;
  logic cs_en_s, cs_tick_s;
  logic hit_p1_s, hit_p2_s;

  // Whole-second prescaler for the start countdown.
  tick_divider #(.DIV(CLK_FREQ)) u_sec_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (sec_en_s),
    .clr_i  (sec_clr_s),
    .tick_o (sec_tick_s)
  );

  // Centisecond prescaler for the race timer; holds across a pause.
  tick_divider #(.DIV(CLK_FREQ / 100)) u_cs_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (cs_en_s),
    .clr_i  (1'b0),
    .tick_o (cs_tick_s)
  );

  // A finish only counts once the player's finish level has been seen low
  // in this race, so a level left high from the last race cannot end it.
  assign hit_p1_s = finish_p1_i & armed_p1_q;
  assign hit_p2_s = finish_p2_i & armed_p2_q;

  // Next-state logic for the race flow, timer, countdown and arming.
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    time_d      = time_q;
    winner_d    = winner_q;
    armed_p1_d  = armed_p1_q;
    armed_p2_d  = armed_p2_q;
    sec_en_s    = 1'b0;
    sec_clr_s   = 1'b0;
    cs_en_s     = 1'b0;

    case (state_q)
      ST_TITLE: begin
        if (start_btn_i) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_TITLE;
        end
      end

      ST_LOAD: begin
        time_d      = 16'd0;
        winner_d    = W_NONE;
        countdown_d = 2'(COUNT_SECS);
        sec_clr_s   = 1'b1;
        state_d     = ST_COUNTDOWN;
      end

      ST_COUNTDOWN: begin
        sec_en_s = 1'b1;
        if (sec_tick_s) begin
          if (countdown_q <= 2'd1) begin
            countdown_d = 2'd0;
            state_d     = ST_RACE;
            armed_p1_d  = ~finish_p1_i;
            armed_p2_d  = ~finish_p2_i;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end else begin
          countdown_d = countdown_q;
        end
      end

      ST_RACE: begin
        cs_en_s = 1'b1;
        if (!armed_p1_q && !finish_p1_i) begin
          armed_p1_d = 1'b1;
        end else begin
          armed_p1_d = armed_p1_q;
        end
        if (!armed_p2_q && !finish_p2_i) begin
          armed_p2_d = 1'b1;
        end else begin
          armed_p2_d = armed_p2_q;
        end
        if (hit_p1_s || hit_p2_s) begin
          winner_d = winner_code(hit_p1_s, hit_p2_s);
          state_d  = ST_FINISHED;
        end else begin
          if (cs_tick_s && (time_q < TIME_MAX)) begin
            time_d = time_q + 16'd1;
          end else begin
            time_d = time_q;
          end
          if (pause_btn_i) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RACE;
          end
        end
      end

      ST_PAUSED: begin
        if (start_btn_i) begin
          state_d = ST_TITLE;
        end else if (pause_btn_i) begin
          state_d = ST_RACE;
        end else begin
          state_d = ST_PAUSED;
        end
      end

      ST_FINISHED: begin
        if (start_btn_i) begin
          state_d = ST_TITLE;
        end else begin
          state_d = ST_FINISHED;
        end
      end

      default: begin
        state_d = ST_TITLE;
      end
    endcase

    car_rst_d = (state_d == ST_TITLE) || (state_d == ST_LOAD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_TITLE;
      car_rst_q   <= 1'b1;
      countdown_q <= 2'd0;
      time_q      <= 16'd0;
      winner_q    <= W_NONE;
      armed_p1_q  <= 1'b0;
      armed_p2_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      car_rst_q   <= car_rst_d;
      countdown_q <= countdown_d;
      time_q      <= time_d;
      winner_q    <= winner_d;
      armed_p1_q  <= armed_p1_d;
      armed_p2_q  <= armed_p2_d;
    end
  end

  assign state_o         = state_q;
  assign car_rst_o       = car_rst_q;
  assign countdown_val_o = countdown_q;
  assign race_time_cs_o  = time_q;
  assign winner_o        = winner_q;

endmodule

// File: tb/tb_race_flow_controller.sv
// Directed bench for race_flow_controller with CLK_FREQ=1000
// (1 s = 1000 cycles, 1 cs = 10 cycles). A second instance with
// TIME_MAX=5 and a 1 s countdown covers timer saturation.
module tb_race_flow_controller;

  logic clk = 1'b0;
  logic rst;
  logic start_btn, pause_btn, finish_p1, finish_p2;
  logic [2:0]  state;
  logic        car_rst;
  logic [1:0]  countdown_val;
  logic [15:0] race_time_cs;
  logic [1:0]  winner;

  logic        start_b;
  logic [2:0]  state_b;
  logic        car_rst_b;
  logic [1:0]  countdown_b;
  logic [15:0] time_b;
  logic [1:0]  winner_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  race_flow_controller #(.CLK_FREQ(1000), .COUNT_SECS(3), .TIME_MAX(16'd65535)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_btn_i     (start_btn),
    .pause_btn_i     (pause_btn),
    .finish_p1_i     (finish_p1),
    .finish_p2_i     (finish_p2),
    .state_o         (state),
    .car_rst_o       (car_rst),
    .countdown_val_o (countdown_val),
    .race_time_cs_o  (race_time_cs),
    .winner_o        (winner)
  );

  race_flow_controller #(.CLK_FREQ(1000), .COUNT_SECS(1), .TIME_MAX(16'd5)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .start_btn_i     (start_b),
    .pause_btn_i     (1'b0),
    .finish_p1_i     (1'b0),
    .finish_p2_i     (1'b0),
    .state_o         (state_b),
    .car_rst_o       (car_rst_b),
    .countdown_val_o (countdown_b),
    .race_time_cs_o  (time_b),
    .winner_o        (winner_b)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the main instance's start button.
  task automatic press_start();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    step(1);
    pause_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0;
    finish_p1 = 1'b0; finish_p2 = 1'b0; start_b = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset values
    check("rst_state",   state, 16'd0);
    check("rst_car_rst", car_rst, 16'd1);
    check("rst_cd",      countdown_val, 16'd0);
    check("rst_time",    race_time_cs, 16'd0);
    check("rst_winner",  winner, 16'd0);
    check("rst_sat_state", state_b, 16'd0);

    // Start: TITLE -> LOAD -> COUNTDOWN
    press_start();
    check("load_state",   state, 16'd1);
    check("load_car_rst", car_rst, 16'd1);
    step(1);
    check("cd_state",   state, 16'd2);
    check("cd_car_rst", car_rst, 16'd0);
    check("cd_val3",    countdown_val, 16'd3);
    step(999);
    check("cd_val3_late", countdown_val, 16'd3);
    step(1);
    check("cd_val2", countdown_val, 16'd2);
    step(1000);
    check("cd_val1", countdown_val, 16'd1);
    step(999);
    check("cd_last_state", state, 16'd2);
    step(1);
    check("race_state", state, 16'd4);
    check("race_cd0",   countdown_val, 16'd0);
    check("race_time0", race_time_cs, 16'd0);

    // P1 finishes after exactly 1000 race cycles
    step(999);
    check("time_99", race_time_cs, 16'd99);
    step(1);
    check("time_100", race_time_cs, 16'd100);
    finish_p1 = 1'b1;
    step(1);
    check("p1_state",  state, 16'd5);
    check("p1_winner", winner, 16'd1);
    check("p1_time",   race_time_cs, 16'd100);
    pause_btn = 1'b1;
    step(1);
    pause_btn = 1'b0;
    step(499);
    check("p1_hold_state",  state, 16'd5);
    check("p1_hold_winner", winner, 16'd1);
    check("p1_hold_time",   race_time_cs, 16'd100);
    finish_p1 = 1'b0;

    // Back to TITLE keeps results visible; LOAD clears them
    press_start();
    check("title_state",  state, 16'd0);
    check("title_winner", winner, 16'd1);
    check("title_time",   race_time_cs, 16'd100);
    press_start();
    step(1);
    check("reload_winner", winner, 16'd0);
    check("reload_time",   race_time_cs, 16'd0);
    step(3000);
    check("tie_race_state", state, 16'd4);

    // Both finish in the same cycle: tie
    step(20);
    finish_p1 = 1'b1; finish_p2 = 1'b1;
    step(1);
    check("tie_state",  state, 16'd5);
    check("tie_winner", winner, 16'd3);
    finish_p1 = 1'b0; finish_p2 = 1'b0;

    // Stale finish_p2 held high through countdown must not end the race
    press_start();
    finish_p2 = 1'b1;
    press_start();
    step(1);
    step(3000);
    check("stale_race_state", state, 16'd4);
    step(100);
    check("stale_state",  state, 16'd4);
    check("stale_winner", winner, 16'd0);
    finish_p2 = 1'b0;
    step(1);
    finish_p2 = 1'b1;
    step(1);
    check("p2_state",  state, 16'd5);
    check("p2_winner", winner, 16'd2);
    finish_p2 = 1'b0;

    // Pause / resume / abort, from a fresh reset for exact prescaler phase
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    press_start();
    step(1);
    step(3000);
    check("pz_race_state", state, 16'd4);
    step(500);
    check("pz_time50", race_time_cs, 16'd50);
    press_pause();
    check("pz_state", state, 16'd3);
    step(400);
    check("pz_hold_state", state, 16'd3);
    check("pz_hold_time",  race_time_cs, 16'd50);
    press_pause();
    check("resume_state", state, 16'd4);
    step(8);
    check("resume_time50", race_time_cs, 16'd50);
    step(1);
    check("resume_time51", race_time_cs, 16'd51);
    press_pause();
    check("pz2_state", state, 16'd3);
    start_btn = 1'b1; pause_btn = 1'b1;
    step(1);
    start_btn = 1'b0; pause_btn = 1'b0;
    check("abort_state",   state, 16'd0);
    check("abort_car_rst", car_rst, 16'd1);
    check("abort_winner",  winner, 16'd0);

    // Pause ignored in countdown, then reset mid-countdown
    press_start();
    step(1);
    step(1500);
    press_pause();
    check("cd_pause_ignored", state, 16'd2);
    check("cd_mid_val",       countdown_val, 16'd2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_state",   state, 16'd0);
    check("midrst_car_rst", car_rst, 16'd1);
    check("midrst_cd",      countdown_val, 16'd0);

    // Saturation instance: TIME_MAX=5
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    step(1);
    check("sat_cd_val", countdown_b, 16'd1);
    step(1000);
    check("sat_race_state", state_b, 16'd4);
    step(50);
    check("sat_time5", time_b, 16'd5);
    step(100);
    check("sat_time_stuck", time_b, 16'd5);
    check("sat_state_hold", state_b, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_flow_controller.md
Name: race_flow_controller

Overview:
- Top-level race sequencer. Drives the 3-bit game `state` bus and the car reset into both per-player physics engines.
- Consumes each engine's `finish` level to decide the winner.
- Runs the start countdown, the race timer (centiseconds) and pause/abort handling.
- Sits upstream of both physics engines (state, car_rst) and downstream of them (finish); its outputs also feed the HUD/renderer.

Parameters:
- CLK_FREQ, 100_000_000, clk frequency in Hz; must be a multiple of 100.
- COUNT_SECS, 3, countdown length in seconds (1..3).
- TIME_MAX, 16'd65535, race timer saturation value in centiseconds.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_btn  in  1  debounced one-cycle pulse
- pause_btn  in  1  debounced one-cycle pulse
- finish_p1  in  1  level, player 1 engine finished
- finish_p2  in  1  level, player 2 engine finished
- state  out  3  game state to engines and HUD
- car_rst  out  1  reset to both physics engines
- countdown_val  out  2  seconds remaining for the HUD
- race_time_cs  out  16  elapsed race time, binary centiseconds
- winner  out  2  0 none, 1 P1, 2 P2, 3 tie

Behaviour:
- Reset: state=TITLE(0), car_rst=1, countdown_val=0, race_time_cs=0, winner=0, all prescalers 0, armed bits 0. All outputs are registered.
- State encoding: 0 TITLE, 1 LOAD, 2 COUNTDOWN, 3 PAUSED, 4 RACE, 5 FINISHED. Codes 6/7 go to TITLE on the next cycle. Engines move only in 4, so 3 freezes cars.
- car_rst=1 while state is TITLE or LOAD, else 0. It is registered together with state.
- TITLE: start_btn -> LOAD.
- LOAD (exactly 1 cycle):
  - clear race_time_cs and winner.
  - countdown_val<=COUNT_SECS.
  - clear the second prescaler.
  - -> COUNTDOWN.
- COUNTDOWN:
  - second prescaler counts 0..CLK_FREQ-1; on wrap, countdown_val decrements.
  - The wrap with countdown_val==1 -> RACE, countdown_val<=0. First RACE cycle is LOAD-exit + COUNT_SECS*CLK_FREQ cycles.
  - start_btn and pause_btn are ignored.
- Finish arming:
  - on the COUNTDOWN->RACE transition, armed_pN<=~finish_pN.
  - while in RACE, a disarmed bit sets once its finish_pN is sampled low.
  - Stale finish levels from a previous race never end the new race.
- RACE:
  - cs prescaler counts 0..CLK_FREQ/100-1; each wrap increments race_time_cs, saturating at TIME_MAX.
  - Let hit_pN = finish_pN & armed_pN.
  - If hit_p1|hit_p2: winner<={hit_p2,hit_p1} mapped to 1/2/3 (both in the same cycle = tie, 3) -> FINISHED. race_time_cs takes no further increment that cycle.
  - Finish has priority over a same-cycle pause_btn.
  - Else pause_btn -> PAUSED.
- PAUSED:
  - timer and cs prescaler hold their values; finish inputs are ignored; armed bits hold.
  - pause_btn -> RACE, resuming the prescaler from its held value.
  - start_btn -> TITLE (abort; winner stays 0).
  - Both pulses in the same cycle: start wins.
- FINISHED: winner and race_time_cs hold. start_btn -> TITLE. pause_btn is ignored.
- TITLE does not clear winner or race_time_cs; they stay visible until the next LOAD.
- rst in any state returns everything to reset values on the next edge.

Decomposition:
- race_pkg holds:
  - state codes ST_TITLE..ST_FINISHED.
  - winner codes W_NONE/W_P1/W_P2/W_TIE.
  - the shared `state` width constant, also used by the physics engines.
- Sub-module tick_divider:
  - params DIV.
  - ports clk, rst, en, clr, tick.
  - prescaler with hold-when-!en.
  - instantiated twice: DIV=CLK_FREQ for seconds, DIV=CLK_FREQ/100 for centiseconds.

Test Plan (CLK_FREQ=1000: 1 s = 1000 cycles, 1 cs = 10 cycles):
- start_btn pulse in TITLE:
  - state 0->1->2, car_rst falls with state=2, countdown_val=3.
  - countdown_val reads 2, 1 at +1000 and +2000 cycles; state=4 and countdown_val=0 at +3000.
- Enter RACE, wait 1000 cycles, pulse finish_p1 -> race_time_cs=100, winner=1, state=5, and both hold for 500 more cycles.
- finish_p1 and finish_p2 rise in the same cycle during RACE -> winner=3, state=5.
- finish_p2 held high through COUNTDOWN into RACE:
  - no finish while it stays high.
  - drop it, raise it again -> winner=2.
- In RACE at race_time_cs=50, pause_btn, wait 400 cycles -> state=3, race_time_cs stays 50.
  - pause_btn again -> state=4, reaching 51 within 10 cycles.
  - pause again, then start_btn -> state=0, car_rst=1, winner=0.
- rst asserted mid-COUNTDOWN -> state=0, car_rst=1, countdown_val=0 on the next edge.
- Force TIME_MAX=16'd5 -> race_time_cs sticks at 5 after 50+ cycles of RACE.
